// File: rtl/manchester_rx.sv
// Oversampled Manchester receiver (IEEE 802.3 polarity): start bit '1' then 8 data bits, MSB first.
// Bit timing re-anchors on each mid-bit edge; a missing mid edge is flagged as a code violation.
module manchester_rx #(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned CNT_W      = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       rx_in,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       busy,
    output logic       err
);

    localparam logic [CNT_W-1:0] MID_LO = CNT_W'(3 * OVERSAMPLE / 4);
    localparam logic [CNT_W-1:0] MID_HI = CNT_W'(5 * OVERSAMPLE / 4);

    typedef enum logic {
        IDLE,
        DATA
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bitcnt;
    logic [7:0]       shift;
    logic             sync1;
    logic             sync2;
    logic             s_d;
    logic             line_edge;
    logic             rise;

    assign line_edge = sync2 ^ s_d;
    assign rise      = sync2 & ~s_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            bitcnt     <= '0;
            shift      <= '0;
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            s_d        <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            sync1      <= rx_in;
            sync2      <= sync1;
            s_d        <= sync2;
            data_valid <= 1'b0;
            err        <= 1'b0;
            if (!ena) begin
                state  <= IDLE;
                cnt    <= '0;
                bitcnt <= '0;
                shift  <= '0;
                busy   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        // The start bit's mid rise anchors the first data cell.
                        if (rise) begin
                            cnt    <= '0;
                            bitcnt <= '0;
                            state  <= DATA;
                            busy   <= 1'b1;
                        end
                    end
                    DATA: begin
                        // An edge in the mid window wins over a coincident timeout.
                        if (line_edge && cnt >= MID_LO) begin
                            shift  <= {shift[6:0], sync2};
                            cnt    <= '0;
                            bitcnt <= bitcnt + 3'd1;
                            if (bitcnt == 3'd7) begin
                                data_out   <= {shift[6:0], sync2};
                                data_valid <= 1'b1;
                                state      <= IDLE;
                                busy       <= 1'b0;
                            end
                        end else if (cnt >= MID_HI) begin
                            err    <= 1'b1;
                            shift  <= '0;
                            cnt    <= '0;
                            bitcnt <= '0;
                            state  <= IDLE;
                            busy   <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
